// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked WIDTH-bit ALU.
//
// Operands are captured when a request is accepted. The issuer may change
// src1/src2/alu_ctrl/comp after that edge.
// Single-cycle ops: the result is visible the cycle after the accept edge.
// Multiplies: one shift-add step per cycle for WIDTH cycles, then the result
// is presented.
//
// Optional feature: define SEQ_ALU_MUL_EN to compile in the MUL op
// (alu_ctrl=1000), the BUSY state and the iterative multiplier. Without it,
// 1000 is an illegal op: result 0, zero 1, latency 1.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous, active-low reset
//   in_valid   in   operation request
//   in_ready   out  block can accept a request this cycle
//   src1       in   operand A
//   src2       in   operand B
//   alu_ctrl   in   0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR,
//                   1101 NAND, 0111 COMP, 1000 MUL
//   comp       in   COMP select: 000 SLT, 001 SGT, 010 SLE, 011 SGE,
//                   110 SEQ, 100 SNE, 101 SLTU (111 -> flag 0)
//   out_valid  out  result/flags valid
//   out_ready  in   consumer takes the result
//   result     out  registered result
//   zero       out  result == 0
//   cout       out  carry out of the MSB (ADD/SUB only)
//   overflow   out  signed overflow (ADD/SUB), unsigned product overflow (MUL)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high, on either side. valid never waits on ready. Once out_valid is high,
// result and flags hold stable until the edge where out_ready is high.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_ctrl,
  input  logic [2:0]       comp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_COMP = 4'b0111;

  localparam logic [2:0] CMP_SLT  = 3'b000;
  localparam logic [2:0] CMP_SGT  = 3'b001;
  localparam logic [2:0] CMP_SLE  = 3'b010;
  localparam logic [2:0] CMP_SGE  = 3'b011;
  localparam logic [2:0] CMP_SEQ  = 3'b110;
  localparam logic [2:0] CMP_SNE  = 3'b100;
  localparam logic [2:0] CMP_SLTU = 3'b101;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CNT_W  = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  state_t state;
  logic   accept;

  // Handshake on the input side
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // Adder shared by ADD and SUB. SUB is src1 + ~src2 + 1.
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_sum;
  logic             add_ovf;

  always_comb begin
    is_sub  = (alu_ctrl == OP_SUB);
    b_eff   = is_sub ? ~src2 : src2;
    add_sum = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    // Overflow: the operands (B after inversion) share a sign that the sum lacks
    add_ovf = (src1[WIDTH-1] == b_eff[WIDTH-1]) &
              (add_sum[WIDTH-1] != src1[WIDTH-1]);
  end

  // Compare flag
  logic lt_s;
  logic lt_u;
  logic eq;
  logic cmp_flag;

  always_comb begin
    lt_s     = $signed(src1) < $signed(src2);
    lt_u     = src1 < src2;
    eq       = (src1 == src2);
    cmp_flag = 1'b0;
    case (comp)
      CMP_SLT:  cmp_flag = lt_s;
      CMP_SGT:  cmp_flag = ~lt_s & ~eq;
      CMP_SLE:  cmp_flag = lt_s | eq;
      CMP_SGE:  cmp_flag = ~lt_s;
      CMP_SEQ:  cmp_flag = eq;
      CMP_SNE:  cmp_flag = ~eq;
      CMP_SLTU: cmp_flag = lt_u;
      default:  cmp_flag = 1'b0;
    endcase
  end

  // Single-cycle result mux. Unknown opcodes fall to the zero default.
  logic [WIDTH-1:0] sc_result;
  logic             sc_cout;
  logic             sc_ovf;

  always_comb begin
    sc_result = '0;
    sc_cout   = 1'b0;
    sc_ovf    = 1'b0;
    case (alu_ctrl)
      OP_AND:  sc_result = src1 & src2;
      OP_OR:   sc_result = src1 | src2;
      OP_NOR:  sc_result = ~(src1 | src2);
      OP_NAND: sc_result = ~(src1 & src2);
      OP_ADD, OP_SUB: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_cout   = add_sum[WIDTH];
        sc_ovf    = add_ovf;
      end
      OP_COMP: sc_result = {{(WIDTH-1){1'b0}}, cmp_flag};
      default: sc_result = '0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  // Iterative multiplier: prod starts as {0, multiplier}.
  // Each step conditionally adds the multiplicand into the upper half and then
  // shifts the whole register right by one, carry included.
  // After WIDTH steps prod holds the full 2*WIDTH-bit product.
  logic                   is_mul;
  logic [WIDTH-1:0]       mcand;
  logic [2*WIDTH-1:0]     prod;
  logic [2*WIDTH-1:0]     prod_next;
  logic [WIDTH:0]         mul_sum;
  logic [CNT_W-1:0]       cnt;

  assign is_mul = (alu_ctrl == OP_MUL);

  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    prod_next = {mul_sum, prod[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef SEQ_ALU_MUL_EN
            if (is_mul) begin
              mcand     <= src1;
              prod      <= {{WIDTH{1'b0}}, src2};
              cnt       <= '0;
              out_valid <= 1'b0;
              state     <= BUSY;
            end else
`endif
            begin
              result    <= sc_result;
              zero      <= (sc_result == '0);
              cout      <= sc_cout;
              overflow  <= sc_ovf;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
`ifdef SEQ_ALU_MUL_EN
        BUSY: begin
          prod <= prod_next;
          cnt  <= cnt + 1'b1;
          // The last step writes the product straight into the output registers
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result    <= prod_next[WIDTH-1:0];
            zero      <= (prod_next[WIDTH-1:0] == '0);
            cout      <= 1'b0;
            overflow  <= |prod_next[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
